// File: rtl/tc_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode codes.
package tc_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Modes 2'b1x are not defined behaviours of their own; they act as one-shot.
   function automatic logic [1:0] effective_mode(input logic [1:0] mode);
      return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
   endfunction

endpackage

// File: rtl/tc_timer_if.sv
// Bridge-to-timer register port: word address, write strobe and data in,
// combinational read data and level interrupt out.
interface tc_timer_if;
   // Handshake: no valid/ready pair. we is a single-cycle write strobe taken on
   // the rising clock edge and never back-pressured; rd follows addr in the
   // same cycle with no request needed; irq is a level, not a pulse.
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   modport master (output addr, output we, output wd, input rd, input irq);
   modport slave  (input addr, input we, input wd, output rd, output irq);
endinterface

// File: rtl/tc_timer.sv
// Countdown timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload
// operation and a maskable level interrupt.
module tc_timer
   import tc_timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   tc_timer_if.slave  bus,
   output state_t     dbg_state
);

   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;
   state_t      state;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        en;
   logic [1:0]  mode;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign wr_ctrl          = bus.we && (bus.addr[3:2] == REG_CTRL);
   assign wr_preset        = bus.we && (bus.addr[3:2] == REG_PRESET);
   assign en               = ctrl[CTRL_EN];
   assign mode             = effective_mode(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
   assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

   // Later non-blocking assignments override earlier ones: a CTRL write clears
   // the flag but an expiry on the same edge sets it again, and a CTRL write
   // overrides the one-shot En clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
         state    <= ST_IDLE;
      end else begin
         if (wr_ctrl) irq_flag <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (en) state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count    <= '0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               state <= ST_IDLE;
               if (mode == MODE_RELOAD) irq_flag <= 1'b0;
               else                     ctrl[CTRL_EN] <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase

         if (wr_ctrl)   ctrl   <= bus.wd[3:0];
         if (wr_preset) preset <= bus.wd;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.addr[3:2])
         REG_CTRL:   rd_mux = {28'b0, ctrl};
         REG_PRESET: rd_mux = preset;
         REG_COUNT:  rd_mux = count;
         default:    rd_mux = '0;
      endcase
   end

   assign bus.rd    = rd_mux;
   assign bus.irq   = irq_flag & ctrl[CTRL_IM];
   assign dbg_state = state;

endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: directed scenarios with hand-derived
// expectations, then randomized traffic against a timeline reference model.
module tb_tc_timer;
   import tc_timer_pkg::*;

   logic   clk;
   logic   reset;
   state_t dbg_state;

   tc_timer_if bus ();

   tc_timer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: a timeline of edge numbers at which the next reload,
   // expiry and post-expiry bookkeeping are due, rather than a state register.
   logic [31:0] m_ctrl = '0;
   logic [31:0] m_preset = '0;
   logic [31:0] m_count = '0;
   logic [31:0] m_load_val = '0;
   bit          m_flag = 1'b0;
   bit          m_active = 1'b0;
   longint      cyc = 0;
   longint      m_load_at = -1;
   longint      m_expire_at = -1;
   longint      m_int_at = -1;

   function automatic logic [31:0] model_rd(input logic [1:0] idx);
      case (idx)
         2'd0:    return m_ctrl;
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit w, input logic [1:0] idx, input logic [31:0] d);
      bit          en, reload, set;
      logic [31:0] n_ctrl, n_count;
      bit          n_flag;
      cyc++;
      if (r) begin
         m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_active = 1'b0;
         m_load_at = -1; m_expire_at = -1; m_int_at = -1;
         return;
      end
      en      = m_ctrl[0];
      reload  = (m_ctrl[2:1] == 2'b01);
      set     = 1'b0;
      n_ctrl  = m_ctrl;
      n_count = m_count;
      n_flag  = m_flag;
      if (!m_active) begin
         if (en) begin
            m_active  = 1'b1;
            m_load_at = cyc + 1;
         end
      end else if (cyc == m_load_at) begin
         m_load_val  = m_preset;
         n_count     = m_preset;
         m_expire_at = cyc + ((m_preset == 0) ? 1 : longint'(m_preset));
      end else if (cyc == m_int_at) begin
         m_active = 1'b0;
         m_int_at = -1;
         if (reload) n_flag = 1'b0;
         else        n_ctrl[0] = 1'b0;
      end else if (!en) begin
         m_active = 1'b0;
      end else if (cyc == m_expire_at) begin
         n_count  = '0;
         set      = 1'b1;
         m_int_at = cyc + 1;
      end else begin
         n_count = m_load_val - 32'(cyc - m_load_at);
      end
      if (w && idx == 2'd0) begin
         n_ctrl = {28'b0, d[3:0]};
         n_flag = 1'b0;
      end
      if (set) n_flag = 1'b1;
      if (w && idx == 2'd1) m_preset = d;
      m_ctrl  = n_ctrl;
      m_count = n_count;
      m_flag  = n_flag;
   endtask

   // driver tasks
   function automatic logic [31:0] make_addr(input logic [1:0] idx);
      logic [31:0] base;
      base = ($urandom_range(0, 1) == 1) ? 32'h0000_7F10 : 32'h0000_7F00;
      return base | {28'b0, idx, 2'b00};
   endfunction

   task automatic rd_reg(input logic [1:0] idx, output logic [31:0] v);
      bus.addr = make_addr(idx);
      #1;
      v = bus.rd;
   endtask

   task automatic step(input bit r, input bit w, input logic [1:0] idx, input logic [31:0] d);
      logic [31:0] v;
      reset    = r;
      bus.we   = w;
      bus.addr = make_addr(idx);
      bus.wd   = d;
      @(posedge clk);
      model_edge(r, w, idx, d);
      #1;
      reset  = 1'b0;
      bus.we = 1'b0;
      bus.wd = '0;
      check("irq", {31'b0, bus.irq}, {31'b0, m_flag & m_ctrl[3]});
      for (int i = 0; i < 4; i++) begin
         rd_reg(i[1:0], v);
         check($sformatf("rd%0d", i), v, model_rd(i[1:0]));
      end
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] d);
      step(1'b0, 1'b1, idx, d);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      logic [1:0]  idx;
      bit          r, w;
      reset    = 1'b1;
      bus.we   = 1'b1;
      bus.wd   = 32'hFFFF_FFFF;
      bus.addr = 32'h0000_7F00;

      // reset with a write pending and all-ones data
      step(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF);
      step(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         rd_reg(i[1:0], v);
         check("reset_rd", v, 32'd0);
      end
      check("reset_irq", {31'b0, bus.irq}, 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      wr(2'd2, 32'h55);
      rd_reg(2'd2, v);
      check("count_ro", v, 32'd0);

      // one-shot, PRESET=3
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      for (int e = 1; e <= 6; e++) begin
         idle();
         if (e >= 2 && e <= 5) begin
            rd_reg(2'd2, v);
            check("os_count", v, 32'(5 - e));
         end
         if (e == 5) check("os_irq_rise", {31'b0, bus.irq}, 32'd1);
      end
      rd_reg(2'd0, v);
      check("os_ctrl", v, 32'h8);
      check("os_irq_hold", {31'b0, bus.irq}, 32'd1);
      wr(2'd0, 32'h8);
      check("os_irq_clr", {31'b0, bus.irq}, 32'd0);

      // auto-reload, PRESET=3 -> period 6
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int e = 1; e <= 18; e++) begin
         idle();
         check($sformatf("ar_irq_e%0d", e), {31'b0, bus.irq}, (e == 5 || e == 11 || e == 17) ? 32'd1 : 32'd0);
      end
      rd_reg(2'd0, v);
      check("ar_ctrl", v, 32'hB);

      // masked expiry
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      for (int e = 1; e <= 6; e++) begin
         idle();
         check("mask_irq", {31'b0, bus.irq}, 32'd0);
      end
      wr(2'd0, 32'h8);
      check("mask_clr_irq", {31'b0, bus.irq}, 32'd0);
      wr(2'd0, 32'h9);
      for (int e = 1; e <= 4; e++) begin
         idle();
         check("mask_reen_irq", {31'b0, bus.irq}, (e == 4) ? 32'd1 : 32'd0);
      end

      // stop mid-count, then restart through a reload
      do_reset();
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      repeat (6) idle();
      rd_reg(2'd2, v);
      check("stop_count6", v, 32'd6);
      wr(2'd0, 32'h8);
      repeat (5) idle();
      rd_reg(2'd2, v);
      check("stop_frozen", v, 32'd5);
      check("stop_state", 32'(dbg_state), 32'd0);
      wr(2'd0, 32'h9);
      repeat (2) idle();
      rd_reg(2'd2, v);
      check("restart_reload", v, 32'd10);

      // PRESET written on the LOAD edge, then reset while counting
      do_reset();
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      idle();
      wr(2'd1, 32'h20);
      rd_reg(2'd2, v);
      check("load_old_preset", v, 32'd5);
      rd_reg(2'd1, v);
      check("load_new_preset", v, 32'h20);
      do_reset();
      rd_reg(2'd2, v);
      check("rst_cnt_count", v, 32'd0);
      check("rst_cnt_state", 32'(dbg_state), 32'd0);

      // PRESET=0 expires right after the load
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      idle();
      idle();
      check("p0_irq_low", {31'b0, bus.irq}, 32'd0);
      idle();
      check("p0_irq_high", {31'b0, bus.irq}, 32'd1);

      // reserved slot
      wr(2'd3, 32'h1234);
      bus.addr = 32'h0000_7F0C;
      #1;
      check("reserved_rd", bus.rd, 32'd0);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         r   = ($urandom_range(0, 199) == 0);
         w   = ($urandom_range(0, 4) == 0);
         idx = 2'($urandom_range(0, 3));
         step(r, w, idx, (idx == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tc_timer.md
Name: tc_timer

Overview:
- Memory-mapped countdown timer device used for both timer0 (0x7F00–0x7F0B) and timer1 (0x7F10–0x7F1B).
- Sits directly downstream of the system bridge.
- Consumes the bridge's word-aligned address, write data and per-timer write enable.
- Returns read data and a level interrupt request that the bridge forwards to the CP0 interrupt inputs.

Parameters:
- None. Data path is fixed at 32 bits; register map is fixed.

Ports:
- clk    input   1   system clock, rising edge
- reset  input   1   synchronous, active-high reset
- addr   input   32  word-aligned device address from bridge; only addr[3:2] decoded
- we     input   1   write enable (bridge asserts only for full-word stores in this timer's range)
- wd     input   32  write data
- rd     output  32  read data, combinational from addr[3:2]
- irq    output  1   interrupt request, level

Behaviour:
- Register map by addr[3:2]:
  - 0 CTRL: bit0 En, bits2:1 Mode, bit3 IM, others read 0.
  - 1 PRESET.
  - 2 COUNT, read-only.
  - 3 reserved: reads 0, writes ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Consequently irq=0 and rd=value of the selected reset register.
- Writes occur on the clock edge with we=1:
  - CTRL <= {28'b0, wd[3:0]}, and irq_flag is cleared.
  - PRESET <= wd.
  - Writes to COUNT or reserved are dropped.
- Mode: 00 = one-shot. 01 = auto-reload. 1x behaves as 00 (CTRL readback keeps the written bits).
- FSM states are IDLE, LOAD, CNT, INT. The FSM evaluates CTRL/PRESET as registered before the current edge.
  - IDLE: if En -> LOAD, else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - if !En -> IDLE, COUNT holds;
    - else if COUNT > 1, COUNT <= COUNT-1;
    - else COUNT <= 0, irq_flag <= 1, -> INT.
  - INT: -> IDLE.
    - Mode 0: clear En; irq_flag holds until the next CTRL write.
    - Mode 1: irq_flag <= 0; En unchanged, so the timer reloads.
- irq = irq_flag & CTRL.IM. This is combinational from registers, so masking takes effect the cycle after the IM write.
- Timing with PRESET=N≥1 and En written at edge E0: LOAD at E1, COUNT=N at E2, irq_flag rises at E(N+2).
  - Mode 1 period = N+3 cycles; irq is high for exactly 1 cycle.
- PRESET=0 or 1: LOAD then expiry on the next edge. No underflow; COUNT never wraps below 0.
- Simultaneous write/FSM at the same edge:
  - A CTRL write wins over the INT-state En clear (write value is stored).
  - A PRESET write during LOAD: LOAD takes the old PRESET.
  - A CTRL write in the same edge the FSM sets irq_flag: the set wins (flag = 1).
- En cleared mid-count: CNT -> IDLE on the next edge; COUNT frozen. Re-enable goes through LOAD, which reloads PRESET (no resume).
- Reset mid-operation returns everything to reset values at that edge, regardless of state or pending we.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3;
  - register offsets CTRL=2'd0, PRESET=2'd1, COUNT=2'd2;
  - CTRL bit indices EN=0, MODE=2:1, IM=3;
  - mode codes ONESHOT=2'b00, RELOAD=2'b01.
- Single flat module; no sub-module needed. The top level instantiates it twice, with the bridge outputs feeding we/addr/wd.

Test Plan:
- Reset with we=1 and wd=0xFFFFFFFF held: after reset all reads are 0 and irq=0. A write to addr 0x7F08 (COUNT) with 0x55 leaves COUNT=0.
- One-shot: PRESET=3, CTRL=0x9.
  - COUNT reads 3,2,1,0 on edges E2–E5; irq rises after E5 and stays high.
  - CTRL reads 0x8 after E6.
  - Writing CTRL=0x8 drops irq the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> irq pulses 1 cycle wide at E5, E11, E17 (period 6); En stays 1.
- Mask: PRESET=2, CTRL=0x1 (IM=0) -> COUNT expires, irq stays 0.
  - Then write CTRL=0x8 -> flag cleared, irq stays 0.
  - Then CTRL=0x9 -> irq after 4 edges.
- Stop/restart: PRESET=10, CTRL=0x9, clear En when COUNT=6 -> COUNT stays 5 (the pending decrement edge) indefinitely. Re-enable -> COUNT reloads to 10.
- Edge cases:
  - PRESET=0 -> irq 2 edges after LOAD.
  - PRESET write 0x20 at the LOAD edge -> COUNT=old value.
  - reset asserted in CNT -> state IDLE, COUNT=0 next edge.
  - addr 0x7F0C read -> 0.
